// File: rtl/e203_tb_irq_injector_if.sv
// Stimulus/observation bundle between the simulation top and the IRQ injector.
interface e203_tb_irq_injector_if #(
  parameter int N_CHAN = 3,
  parameter int CNT_W  = 32
);
  logic [15:0]             seed;
  logic                    arm;
  logic                    stop;
  logic [N_CHAN-1:0]       ack;
  logic [N_CHAN-1:0]       irq;
  logic [N_CHAN*CNT_W-1:0] fire_cnt;
  logic [N_CHAN-1:0]       tmo_err;
  logic                    quiet;

  modport master (
    output seed, arm, stop, ack,
    input  irq, fire_cnt, tmo_err, quiet
  );

  modport slave (
    input  seed, arm, stop, ack,
    output irq, fire_cnt, tmo_err, quiet
  );
endinterface

// File: rtl/e203_tb_irq_injector.sv
// N-channel pseudo-random interrupt injector for the e203 simulation top.
//
// state  | meaning
// S_OFF  | idle after reset, waiting for arm
// S_WAIT | random gap running on the down-counter, irq low
// S_FIRE | irq high, waiting for handler ack; counter tracks ack timeout
// S_HALT | stopped or timed out; left only through reset
module e203_tb_irq_injector #(
  parameter int N_CHAN  = 3,
  parameter int GAP_W   = 10,
  parameter int MIN_GAP = 1,
  parameter int TMO_CYC = 4096,
  parameter int CNT_W   = 32
) (
  input  logic                     hfclk,
  input  logic                     rst_n,
  e203_tb_irq_injector_if.slave    bus
);

  localparam int GAP_MAX = MIN_GAP + (1 << GAP_W) - 1;
  localparam int GAP_B   = $clog2(GAP_MAX + 1);
  localparam int TMO_B   = $clog2(TMO_CYC + 1);
  localparam int TMR_W   = (GAP_B > TMO_B) ? GAP_B : TMO_B;

  typedef enum logic [1:0] {S_OFF, S_WAIT, S_FIRE, S_HALT} state_t;

  logic [N_CHAN-1:0]       irq_v;
  logic [N_CHAN-1:0]       tmo_v;
  logic [N_CHAN-1:0]       halt_v;
  logic [N_CHAN*CNT_W-1:0] cnt_v;
  logic                    quiet_q;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  genvar i;
  generate
    for (i = 0; i < N_CHAN; i++) begin : g_chan
      state_t           state_q, state_d;
      logic [TMR_W-1:0] tmr_q, tmr_d;
      logic [15:0]      lfsr_q, lfsr_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             irq_q;
      logic             tmo_q, tmo_d;
      logic [15:0]      seed_mix;
      logic [15:0]      seed_eff;
      logic [15:0]      gap_src;
      logic [TMR_W-1:0] gap_m1;

      // The seed only matters on the first gap load; afterwards the LFSR runs on its own.
      assign seed_mix = bus.seed ^ 16'(i);
      assign seed_eff = (seed_mix == 16'h0000) ? 16'hACE1 : seed_mix;
      assign gap_src  = (state_q == S_OFF) ? seed_eff : lfsr_q;
      // Counter is loaded with gap-1 so terminal count is zero.
      assign gap_m1   = TMR_W'(MIN_GAP - 1) + TMR_W'(gap_src[GAP_W-1:0]);

      // Next-state, timer, LFSR and counter update for one channel.
      always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
          S_OFF: begin
            if (bus.arm) begin
              if (bus.stop) begin
                state_d = S_HALT;
              end else begin
                state_d = S_WAIT;
                tmr_d   = gap_m1;
                lfsr_d  = lfsr_step(gap_src);
              end
            end
          end
          S_WAIT: begin
            if (bus.stop) begin
              state_d = S_HALT;
            end else if (tmr_q == '0) begin
              state_d = S_FIRE;
              tmr_d   = TMR_W'(TMO_CYC - 1);
            end else begin
              tmr_d = tmr_q - 1'b1;
            end
          end
          S_FIRE: begin
            // Ack is checked before the timeout so a last-cycle ack still counts.
            if (bus.ack[i]) begin
              if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
              if (bus.stop) begin
                state_d = S_HALT;
              end else begin
                state_d = S_WAIT;
                tmr_d   = gap_m1;
                lfsr_d  = lfsr_step(gap_src);
              end
            end else if (tmr_q == '0) begin
              tmo_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              tmr_d = tmr_q - 1'b1;
            end
          end
          default: begin
          end
        endcase
      end

      // Channel state register; irq is a flop of the next state to keep it glitch-free.
      always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= S_OFF;
          tmr_q   <= '0;
          lfsr_q  <= '0;
          cnt_q   <= '0;
          tmo_q   <= 1'b0;
          irq_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          tmr_q   <= tmr_d;
          lfsr_q  <= lfsr_d;
          cnt_q   <= cnt_d;
          tmo_q   <= tmo_d;
          irq_q   <= (state_d == S_FIRE);
        end
      end

      assign irq_v[i]                  = irq_q;
      assign tmo_v[i]                  = tmo_q;
      assign halt_v[i]                 = (state_q == S_HALT);
      assign cnt_v[i*CNT_W +: CNT_W]   = cnt_q;
    end
  endgenerate

  // Quiet follows the last channel into HALT by one cycle.
  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) quiet_q <= 1'b0;
    else        quiet_q <= &halt_v;
  end

  assign bus.irq      = irq_v;
  assign bus.tmo_err  = tmo_v;
  assign bus.fire_cnt = cnt_v;
  assign bus.quiet    = quiet_q;

endmodule

// File: tb/tb_e203_tb_irq_injector.sv
module tb_e203_tb_irq_injector;
  localparam int N   = 3;
  localparam int GW  = 4;
  localparam int MG  = 1;
  localparam int TMO = 16;
  localparam int CW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic hfclk = 1'b0;
  logic rst_n = 1'b0;

  e203_tb_irq_injector_if #(.N_CHAN(N), .CNT_W(CW)) bus ();

  e203_tb_irq_injector #(
    .N_CHAN(N), .GAP_W(GW), .MIN_GAP(MG), .TMO_CYC(TMO), .CNT_W(CW)
  ) dut (
    .hfclk(hfclk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 hfclk = ~hfclk;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute edge times for each channel's next rise and fire start.
  int          now;
  bit          m_armed  [N];
  bit          m_firing [N];
  bit          m_halted [N];
  bit          m_tmo    [N];
  int          m_rise   [N];
  int          m_fire_at[N];
  int          m_cnt    [N];
  logic [15:0] m_lfsr   [N];
  bit          m_quiet;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int gap_of(input logic [15:0] l);
    return MG + int'(l[GW-1:0]);
  endfunction

  task automatic model_reset();
    now = 0;
    m_quiet = 1'b0;
    for (int c = 0; c < N; c++) begin
      m_armed[c] = 0; m_firing[c] = 0; m_halted[c] = 0; m_tmo[c] = 0;
      m_rise[c] = 0; m_fire_at[c] = 0; m_cnt[c] = 0; m_lfsr[c] = '0;
    end
  endtask

  task automatic model_edge();
    bit all_h;
    logic [15:0] l;
    all_h = 1'b1;
    for (int c = 0; c < N; c++) if (!m_halted[c]) all_h = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (m_halted[c]) begin
      end else if (!m_armed[c]) begin
        if (bus.arm) begin
          if (bus.stop) m_halted[c] = 1;
          else begin
            l = bus.seed ^ 16'(c);
            if (l == 16'h0000) l = 16'hACE1;
            m_armed[c] = 1;
            m_rise[c]  = now + gap_of(l);
            m_lfsr[c]  = lfsr_adv(l);
          end
        end
      end else if (!m_firing[c]) begin
        if (bus.stop) m_halted[c] = 1;
        else if (now == m_rise[c]) begin
          m_firing[c]  = 1;
          m_fire_at[c] = now;
        end
      end else begin
        if (bus.ack[c]) begin
          if (m_cnt[c] < CMAX) m_cnt[c]++;
          m_firing[c] = 0;
          if (bus.stop) m_halted[c] = 1;
          else begin
            m_rise[c] = now + gap_of(m_lfsr[c]);
            m_lfsr[c] = lfsr_adv(m_lfsr[c]);
          end
        end else if (now - m_fire_at[c] == TMO) begin
          m_tmo[c] = 1; m_firing[c] = 0; m_halted[c] = 1;
        end
      end
    end
    m_quiet = all_h;
  endtask

  function automatic logic [N-1:0] exp_irq();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = m_firing[c];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_tmo();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = m_tmo[c];
    return r;
  endfunction

  function automatic logic [N*CW-1:0] exp_cnt();
    logic [N*CW-1:0] r;
    for (int c = 0; c < N; c++) r[c*CW +: CW] = CW'(m_cnt[c]);
    return r;
  endfunction

  function automatic logic [N-1:0] rand_ack();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: model consumes the current inputs, DUT outputs compared at the next negedge.
  task automatic step();
    now++;
    model_edge();
    @(posedge hfclk);
    @(negedge hfclk);
    chk("irq",      32'(bus.irq),      32'(exp_irq()));
    chk("tmo_err",  32'(bus.tmo_err),  32'(exp_tmo()));
    chk("quiet",    32'(bus.quiet),    32'(m_quiet));
    chk("fire_cnt", 32'(bus.fire_cnt), 32'(exp_cnt()));
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge hfclk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int hi0;
    bus.seed = 16'h0000; bus.arm = 1'b0; bus.stop = 1'b0; bus.ack = '0;
    model_reset();
    @(negedge hfclk);
    @(negedge hfclk);
    chk("rst_irq",   32'(bus.irq),      32'h0);
    chk("rst_cnt",   32'(bus.fire_cnt), 32'h0);
    chk("rst_tmo",   32'(bus.tmo_err),  32'h0);
    chk("rst_quiet", 32'(bus.quiet),    32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // seed 0 -> ACE1: gaps 2 then 4 on channel 0
    bus.seed = 16'h0000; bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    step();
    chk("seed0_before_rise", 32'(bus.irq[0]), 32'h0);
    step();
    chk("seed0_rise_gap2", 32'(bus.irq[0]), 32'h1);
    bus.ack = 3'b001;
    step();
    chk("ack_drop", 32'(bus.irq[0]), 32'h0);
    chk("ack_count", 32'(bus.fire_cnt[CW-1:0]), 32'h1);
    bus.ack = 3'b000;
    for (int k = 0; k < 3; k++) step();
    chk("seed0_before_rise2", 32'(bus.irq[0]), 32'h0);
    step();
    chk("seed0_rise_gap4", 32'(bus.irq[0]), 32'h1);

    // random acks, then drain
    for (int k = 0; k < 250; k++) begin
      bus.ack = rand_ack();
      step();
    end
    bus.stop = 1'b1;
    for (int k = 0; k < 60 && !bus.quiet; k++) begin
      bus.ack = rand_ack();
      step();
    end
    chk("drain_quiet", 32'(bus.quiet), 32'h1);
    bus.stop = 1'b0; bus.ack = '0;

    // ack held constantly: each fire counts once, counters saturate
    sync_reset();
    bus.seed = 16'h0000; bus.arm = 1'b1; bus.ack = 3'b111;
    step();
    bus.arm = 1'b0;
    for (int k = 0; k < 100; k++) step();
    chk("sat_ch0", 32'(bus.fire_cnt[0*CW +: CW]), 32'(CMAX));
    chk("sat_ch1", 32'(bus.fire_cnt[1*CW +: CW]), 32'(CMAX));
    chk("sat_ch2", 32'(bus.fire_cnt[2*CW +: CW]), 32'(CMAX));

    // async reset while irq is high
    bus.ack = '0;
    for (int k = 0; k < 40 && bus.irq == '0; k++) step();
    chk("wait_irq", 32'(bus.irq != '0), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_irq", 32'(bus.irq),      32'h0);
    chk("rst_async_cnt", 32'(bus.fire_cnt), 32'h0);
    model_reset();
    @(negedge hfclk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("no_rearm_irq", 32'(bus.irq), 32'h0);

    // no acks: every channel times out after exactly TMO cycles high
    bus.seed = 16'($urandom); bus.arm = 1'b1;
    hi0 = 0;
    step();
    bus.arm = 1'b0;
    for (int k = 0; k < 45; k++) begin
      step();
      if (bus.irq[0]) hi0++;
    end
    chk("tmo_hold_cycles", 32'(hi0),           32'(TMO));
    chk("tmo_all",         32'(bus.tmo_err),   32'h7);
    chk("tmo_quiet",       32'(bus.quiet),     32'h1);
    chk("tmo_counts",      32'(bus.fire_cnt),  32'h0);

    // arm with stop in OFF goes straight to HALT
    sync_reset();
    bus.arm = 1'b1; bus.stop = 1'b1;
    step();
    chk("armstop_quiet_lag", 32'(bus.quiet), 32'h0);
    step();
    chk("armstop_quiet", 32'(bus.quiet), 32'h1);
    chk("armstop_irq",   32'(bus.irq),   32'h0);

    // stop with ch0/ch2 firing and ch1 still waiting
    sync_reset();
    bus.stop = 1'b0; bus.seed = 16'h0002; bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("pre_stop_irq", 32'(bus.irq), 32'h5);
    bus.stop = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("stop_wait_no_irq", 32'(bus.irq), 32'h5);
    bus.ack = 3'b111;
    step();
    chk("drain_irq", 32'(bus.irq),      32'h0);
    chk("drain_cnt", 32'(bus.fire_cnt), 32'h11);
    chk("drain_quiet_lag", 32'(bus.quiet), 32'h0);
    bus.ack = 3'b000;
    step();
    chk("drain_quiet_set", 32'(bus.quiet), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
